mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main controller. Sequences every instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and muxes.
- Produces the 4-bit `aluop` consumed by the ALU decoder. Encoding: 0000 add, 0001 sub, 0010 R-type (decode funct), 0011 lui, 0100 or, 0101 and, 0111 xor.
- Adds a memory wait-state handshake so the shared instruction/data memory may stall.

Parameters:
- WAIT_EN, 1: 1 means `memready` is honoured; 0 means `memready` is internally forced to 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  6  opcode from the instruction register; stable from DECODE until the next FETCH completes
- memready  input  1  memory access completes this cycle
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- pcwrite  output  1  unconditional PC load
- branch  output  1  PC load if zero (beq)
- branchne  output  1  PC load if not zero (bne)
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alusrca  output  1  0 = PC, 1 = A register
- alusrcb  output  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = immediate shifted left by 2
- zeroext  output  1  1 means the immediate is zero-extended (andi/ori/xori)
- regdst  output  1  1 means destination is rd, 0 means rt
- memtoreg  output  1  1 means writeback data comes from the data register
- regwrite  output  1  register file write
- aluop  output  4  to the ALU decoder
- illegal  output  1  one-cycle pulse on an unsupported opcode
- state  output  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11. Codes 12–15 are unused.
- On a rising clk with reset=1, state becomes FETCH. While reset=1, every write/strobe output (memwrite, irwrite, pcwrite, branch, branchne, regwrite, illegal) is forced to 0.
- Outputs are Moore, decoded from state. In IMMEX, aluop and zeroext also depend on op. Any output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=0000, pcsrc=00, irwrite=memready, pcwrite=memready.
  - Stays in FETCH while memready=0; goes to DECODE when memready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=0000. Next state depends on op:
  - 100011 (lw) or 101011 (sw) go to MEMADR.
  - 000000 goes to EXEC.
  - 000100 (beq) or 000101 (bne) go to BRANCH.
  - 001000, 001100, 001101, 001110, 001111 go to IMMEX.
  - 000010 goes to JUMP.
  - Any other op goes to FETCH with illegal=1 during this DECODE cycle; the instruction is a no-op.
- MEMADR: alusrca=1, alusrcb=10, aluop=0000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Holds until memready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1, held asserted until memready=1, then goes to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=0010. Goes to ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=0001, pcsrc=01. branch=1 if op=000100; branchne=1 if op=000101. Goes to FETCH.
- IMMEX: alusrca=1, alusrcb=10. Goes to IMMWB.
  - aluop: addi 0000, andi 0101, ori 0100, xori 0111, lui 0011.
  - zeroext=1 for andi/ori/xori; 0 for addi/lui.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.
- Latency with zero wait states, in cycles including FETCH: lw 5; sw 4; R-type 4; immediate ops 4; beq/bne 3; j 3; illegal 2.
- Each wait cycle (memready=0 in FETCH, MEMRD or MEMWR) adds exactly one cycle.
- Mid-instruction reset: the next edge goes to FETCH. No regwrite or memwrite may occur during or after the reset cycle for the aborted instruction.
- If state ever holds an unused code (12–15), next state is FETCH and all strobes are 0.

Test Plan:
- Reset held 2 cycles, then released with memready=1 and op=000000 → state sequence 0,1,6,7,0. aluop=0010 in EXEC; regwrite=1, regdst=1 only in ALUWB.
- lw (100011), with memready=0 for 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. iord=1 throughout MEMRD; regwrite=1, memtoreg=1 in MEMWB.
- sw (101011), with memready low 1 cycle in FETCH → irwrite and pcwrite stay 0 until memready=1. memwrite=1 for both MEMWR cycles when memready is low for 1 cycle there.
- op sweep in IMMEX: 001100 → aluop=0101, zeroext=1; 001101 → 0100, 1; 001110 → 0111, 1; 001111 → 0011, 0; 001000 → 0000, 0.
- bne (000101) → BRANCH with aluop=0001, pcsrc=01, branchne=1, branch=0. j (000010) → JUMP with pcsrc=10, pcwrite=1. op=111111 → illegal=1 for one cycle, then FETCH.
- reset asserted during MEMWB → regwrite=0 that cycle; state=FETCH after the edge. WAIT_EN=0 with memready tied to 0 → lw completes in 5 cycles.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main controller with memory wait-state handshake
module mc_ctrl_fsm #(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchne,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [3:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  state_t r_state;
  logic w_ready, w_lw, w_sw, w_rtype, w_beq, w_bne, w_imm, w_j, w_legal;
  assign w_ready = WAIT_EN ? memready : 1'b1;
  assign w_lw    = op == 6'b100011;
  assign w_sw    = op == 6'b101011;
  assign w_rtype = op == 6'b000000;
  assign w_beq   = op == 6'b000100;
  assign w_bne   = op == 6'b000101;
  assign w_imm   = op == 6'b001000 || (op[5:2] == 4'b0011);
  assign w_j     = op == 6'b000010;
  assign w_legal = w_lw | w_sw | w_rtype | w_beq | w_bne | w_imm | w_j;
  assign state   = r_state;
  // state sequencing; wait states hold FETCH, MEMRD and MEMWR until memory is ready
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else case (r_state)
      S_FETCH:  r_state <= w_ready ? S_DECODE : S_FETCH;
      S_DECODE: r_state <= (w_lw | w_sw) ? S_MEMADR : w_rtype ? S_EXEC :
                           (w_beq | w_bne) ? S_BRANCH : w_imm ? S_IMMEX :
                           w_j ? S_JUMP : S_FETCH;
      S_MEMADR: r_state <= w_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  r_state <= w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  r_state <= w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   r_state <= S_ALUWB;
      S_IMMEX:  r_state <= S_IMMWB;
      default:  r_state <= S_FETCH;
    endcase
  end
  // Moore output decode; strobes are suppressed while reset is asserted
  always_comb begin
    {iord, memwrite, irwrite, pcwrite, branch, branchne, alusrca} = '0;
    {zeroext, regdst, memtoreg, regwrite, illegal} = '0;
    pcsrc   = 2'b00;
    alusrcb = 2'b00;
    aluop   = 4'b0000;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = w_ready;
        pcwrite = w_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~w_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 4'b0010;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 4'b0001;
        pcsrc    = 2'b01;
        branch   = w_beq;
        branchne = w_bne;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = op[2] & ~(op[1] & op[0]);
        aluop   = ~op[2] ? 4'b0000 : op[1:0] == 2'b00 ? 4'b0101 :
                  op[1:0] == 2'b01 ? 4'b0100 : op[1:0] == 2'b10 ? 4'b0111 : 4'b0011;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) {memwrite, irwrite, pcwrite, branch, branchne, regwrite, illegal} = '0;
  end
endmodule
